// File: rtl/valet_pkg.sv
// valet_pkg: shared sequencer state encoding and sizing limits.
package valet_pkg;
  typedef enum logic [1:0] {SEQ_IDLE, SEQ_RUN, SEQ_GAP, SEQ_FIN} seq_state_t;
  localparam int MAX_PHASES = 16;
endpackage

// File: rtl/phase_sequencer_if.sv
// phase_sequencer_if: command/timer handshake between the sequencer and its environment.
interface phase_sequencer_if #(parameter int NUM_PHASES = 4);
  localparam int PHASE_W = $clog2(NUM_PHASES > 1 ? NUM_PHASES : 2);
  logic start;
  logic abort;
  logic timer_done;
  logic timer_en;
  logic busy;
  logic phase_adv;
  logic seq_done;
  logic seq_abort;
  logic [PHASE_W-1:0] phase;
  modport master (
    output start, abort, timer_done,
    input  timer_en, phase, busy, phase_adv, seq_done, seq_abort
  );
  modport slave (
    input  start, abort, timer_done,
    output timer_en, phase, busy, phase_adv, seq_done, seq_abort
  );
endinterface

// File: rtl/phase_sequencer.sv
// phase_sequencer: runs NUM_PHASES timed phases per start, driving one downstream timer.
module phase_sequencer
  import valet_pkg::*;
#(
  parameter int NUM_PHASES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  phase_sequencer_if.slave sif
);
  localparam int PHASE_W = $clog2(NUM_PHASES > 1 ? NUM_PHASES : 2);
  localparam logic [PHASE_W-1:0] LAST = PHASE_W'(NUM_PHASES - 1);

  seq_state_t         state_q, state_d;
  logic [PHASE_W-1:0] phase_q, phase_d;
  logic               timer_en_q, timer_en_d;
  logic               busy_q, busy_d;
  logic               phase_adv_q, phase_adv_d;
  logic               seq_done_q, seq_done_d;
  logic               seq_abort_q, seq_abort_d;

  // Outputs are computed for the state being entered so every port is a flop.
  always_comb begin
    state_d     = state_q;
    phase_d     = phase_q;
    timer_en_d  = 1'b0;
    busy_d      = 1'b0;
    phase_adv_d = 1'b0;
    seq_done_d  = 1'b0;
    seq_abort_d = 1'b0;
    if (state_q != SEQ_IDLE && sif.abort) begin
      state_d     = SEQ_IDLE;
      phase_d     = '0;
      seq_abort_d = 1'b1;
    end else begin
      case (state_q)
        SEQ_IDLE: begin
          if (sif.start && !sif.abort) begin
            state_d    = SEQ_RUN;
            phase_d    = '0;
            timer_en_d = 1'b1;
            busy_d     = 1'b1;
          end
        end
        SEQ_RUN: begin
          busy_d      = 1'b1;
          timer_en_d  = !sif.timer_done;
          state_d     = !sif.timer_done ? SEQ_RUN : (phase_q == LAST ? SEQ_FIN : SEQ_GAP);
          seq_done_d  = sif.timer_done && phase_q == LAST;
          phase_adv_d = sif.timer_done && phase_q != LAST;
          phase_d     = phase_adv_d ? phase_q + PHASE_W'(1) : phase_q;
        end
        SEQ_GAP: begin
          state_d    = SEQ_RUN;
          timer_en_d = 1'b1;
          busy_d     = 1'b1;
        end
        default: begin
          state_d = SEQ_IDLE;
          phase_d = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= SEQ_IDLE;
      phase_q     <= '0;
      timer_en_q  <= 1'b0;
      busy_q      <= 1'b0;
      phase_adv_q <= 1'b0;
      seq_done_q  <= 1'b0;
      seq_abort_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      timer_en_q  <= timer_en_d;
      busy_q      <= busy_d;
      phase_adv_q <= phase_adv_d;
      seq_done_q  <= seq_done_d;
      seq_abort_q <= seq_abort_d;
    end
  end

  assign sif.timer_en  = timer_en_q;
  assign sif.phase     = phase_q;
  assign sif.busy      = busy_q;
  assign sif.phase_adv = phase_adv_q;
  assign sif.seq_done  = seq_done_q;
  assign sif.seq_abort = seq_abort_q;
endmodule

// File: tb/tb_phase_sequencer.sv
// tb_phase_sequencer: scoreboard bench for a 3-phase and a 1-phase sequencer, each paired with a DURATION=4 timer.
module tb_phase_sequencer;
  localparam int D = 4;
  localparam int NA = 3;
  localparam int NB = 1;

  typedef struct {
    int         c;
    logic [2:0] kind;
  } ev_t;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_err = 0;
  bit   mon_on = 1'b0;
  int   s[2] = '{-1, -1};
  int   ab[2] = '{-1, -1};
  ev_t  q0[$];
  ev_t  q1[$];
  int   cnt_a, cnt_b;
  logic stray_a = 1'b0;
  logic stray_b = 1'b0;

  phase_sequencer_if #(.NUM_PHASES(NA)) a_if ();
  phase_sequencer_if #(.NUM_PHASES(NB)) b_if ();

  phase_sequencer #(.NUM_PHASES(NA)) dut_a (.clk(clk), .rst_n(rst_n), .sif(a_if.slave));
  phase_sequencer #(.NUM_PHASES(NB)) dut_b (.clk(clk), .rst_n(rst_n), .sif(b_if.slave));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Timer: count clears while disabled, counts 0..D while enabled, done is a level at D.
  always @(posedge clk or negedge rst_n)
    if (!rst_n) cnt_a <= 0;
    else cnt_a <= !a_if.timer_en ? 0 : (cnt_a == D ? cnt_a : cnt_a + 1);
  always @(posedge clk or negedge rst_n)
    if (!rst_n) cnt_b <= 0;
    else cnt_b <= !b_if.timer_en ? 0 : (cnt_b == D ? cnt_b : cnt_b + 1);
  assign a_if.timer_done = (a_if.timer_en && cnt_a == D) || stray_a;
  assign b_if.timer_done = (b_if.timer_en && cnt_b == D) || stray_b;

  // A sequence started in cycle st is busy for n*(D+2) cycles; each phase is D+1 RUN cycles
  // followed by one disabled cycle (GAP, or FIN after the last phase). An abort in cycle ab ends it.
  function automatic void model(input int n, input int c, input int st, input int a,
                                output logic b, output logic e, output int ph);
    int o = c - st - 1;
    b = 1'b0; e = 1'b0; ph = 0;
    if (st < 0 || o < 0 || o >= n * (D + 2) || (a >= 0 && c > a)) return;
    b  = 1'b1;
    ph = (o + 1) / (D + 2) > n - 1 ? n - 1 : (o + 1) / (D + 2);
    e  = (o % (D + 2)) != D + 1;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d got=%0d expected=%0d", nm, cyc, act, exp);
    end
  endtask

  task automatic push(input int k, input int c, input logic [2:0] kind);
    ev_t ev;
    ev.c = c; ev.kind = kind;
    if (k == 0) q0.push_back(ev); else q1.push_back(ev);
  endtask

  task automatic mon(input int k, input logic b, input logic e, input int ph, input logic [2:0] pl);
    logic eb, ee;
    int eph;
    logic [2:0] ek = 3'b000;
    model(k ? NB : NA, cyc, s[k], ab[k], eb, ee, eph);
    chk($sformatf("levels%0d{busy,en,phase}", k), {b, e} * 100 + ph, {eb, ee} * 100 + eph);
    if (k == 0 && q0.size() > 0 && q0[0].c == cyc) begin ek = q0[0].kind; void'(q0.pop_front()); end
    if (k == 1 && q1.size() > 0 && q1[0].c == cyc) begin ek = q1[0].kind; void'(q1.pop_front()); end
    if (pl != 3'b000 || ek != 3'b000) chk($sformatf("pulse%0d{abort,done,adv}", k), int'(pl), int'(ek));
  endtask

  always @(negedge clk) if (mon_on) begin
    mon(0, a_if.busy, a_if.timer_en, int'(a_if.phase), {a_if.seq_abort, a_if.seq_done, a_if.phase_adv});
    mon(1, b_if.busy, b_if.timer_en, int'(b_if.phase), {b_if.seq_abort, b_if.seq_done, b_if.phase_adv});
  end

  task automatic tick();
    logic eb, ee;
    int eph;
    @(posedge clk);
    #1;
    a_if.start = 1'b0;
    b_if.start = 1'b0;
    a_if.abort = (cyc == ab[0]);
    b_if.abort = (cyc == ab[1]);
    model(NA, cyc, s[0], ab[0], eb, ee, eph);
    stray_a = !ee && ($urandom_range(0, 2) == 0);
    model(NB, cyc, s[1], ab[1], eb, ee, eph);
    stray_b = !ee && ($urandom_range(0, 2) == 0);
  endtask

  task automatic launch(input int k, input int off);
    int n = k ? NB : NA;
    int a = off < 0 ? -1 : cyc + 1 + off;
    s[k] = cyc;
    ab[k] = a;
    if (k == 1) b_if.start = 1'b1; else a_if.start = 1'b1;
    for (int p = 0; p < n - 1; p++) begin
      int c = cyc + 1 + p * (D + 2) + D + 1;
      if (a < 0 || c <= a) push(k, c, 3'b001);
    end
    if (a < 0) push(k, cyc + n * (D + 2), 3'b010);
    else push(k, a + 1, 3'b100);
  endtask

  task automatic run(input int k, input int off);
    launch(k, off);
    repeat ((k ? NB : NA) * (D + 2) + 1) tick();
  endtask

  function automatic int all_out();
    return {a_if.timer_en, a_if.busy, a_if.phase_adv, a_if.seq_done, a_if.seq_abort, a_if.phase,
            b_if.timer_en, b_if.busy, b_if.phase_adv, b_if.seq_done, b_if.seq_abort, b_if.phase};
  endfunction

  initial begin
    a_if.start = 1'b0; a_if.abort = 1'b0;
    b_if.start = 1'b0; b_if.abort = 1'b0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1 mon_on = 1'b1;
    repeat (3) tick();
    chk("reset_outputs", all_out(), 0);
    rst_n = 1'b1;
    repeat (20) tick();
    chk("idle_timer_en", int'(a_if.timer_en), 0);
    // full sequence, then abort inside phase 1, then a normal run after the abort
    run(0, -1);
    run(0, D + 4);
    run(0, -1);
    // abort together with the final timer_done
    run(0, (NA - 1) * (D + 2) + D);
    // start while busy in phase 1 is ignored; start in the first idle cycle after FIN is taken
    launch(0, -1);
    repeat (D + 4) tick();
    a_if.start = 1'b1;
    repeat (NA * (D + 2) + 1 - (D + 4)) tick();
    run(0, -1);
    // abort with start in idle: no effect
    tick();
    a_if.start = 1'b1; a_if.abort = 1'b1;
    b_if.start = 1'b1; b_if.abort = 1'b1;
    repeat (3) tick();
    run(1, -1);
    run(1, 2);
    repeat (16) begin
      int k = int'($urandom_range(0, 1));
      int l = (k ? NB : NA) * (D + 2);
      run(k, $urandom_range(0, 1) ? -1 : int'($urandom_range(0, l - 2)));
      repeat ($urandom_range(0, 3)) tick();
    end
    // asynchronous reset in the middle of the first GAP
    launch(0, -1);
    repeat (D + 2) tick();
    #1;
    s = '{-1, -1}; ab = '{-1, -1};
    q0.delete(); q1.delete();
    rst_n = 1'b0;
    #1 chk("async_reset_outputs", all_out(), 0);
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (12) tick();
    chk("leftover_events_a", q0.size(), 0);
    chk("leftover_events_b", q1.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
